// File: rtl/add_sched_pkg.sv
// Shared types for the add_sched scheduler: FSM states and statistics counter width.
// No logic; the saturating increment helper is used by the optional grant counters.
package add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int STATS_W = 8;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/add_unit.sv
// Registered unsigned adder: sum loads a+b (full DW+1 width) on the clock after en, one cycle latency.
// No backpressure; sum holds its value while en is low.
module add_unit #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW:0]   sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (en) begin
      sum <= {1'b0, a} + {1'b0, b};
    end
  end

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one registered adder; response 2 cycles after grant, one txn in flight.
// Holds the response until rsp_ready; optional per-requester grant counters under ADD_SCHED_STATS_EN.
module add_sched
  import add_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DW-1:0]      req_a,
  input  logic [NUM_REQ*DW-1:0]      req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DW:0]                rsp_sum,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id
`ifdef ADD_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] grant_cnt
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic           found;
  logic           hs;
  logic           calc_en;
  logic [DW-1:0]  op_a;
  logic [DW-1:0]  op_b;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // First valid requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[rr_idx(rr_ptr, k)]) begin
        found = 1'b1;
        win   = rr_idx(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is suppressed while rst_n is low so nothing is offered during reset.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    calc_en   = 1'b0;
    case (state)
      IDLE:    if (rst_n && found) req_ready[win] = 1'b1;
      CALC:    calc_en = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign hs = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      rsp_id <= '0;
      op_a   <= '0;
      op_b   <= '0;
    end else if (hs) begin
      op_a   <= req_a[int'(win)*DW +: DW];
      op_b   <= req_b[int'(win)*DW +: DW];
      rsp_id <= win;
      rr_ptr <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  add_unit #(
    .DW(DW)
  ) u_add (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (calc_en),
    .a    (op_a),
    .b    (op_b),
    .sum  (rsp_sum)
  );

`ifdef ADD_SCHED_STATS_EN
  logic [STATS_W-1:0] cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (hs) begin
      cnt[win] <= sat_inc(cnt[win]);
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    assign grant_cnt[gi*STATS_W +: STATS_W] = cnt[gi];
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 Parameter DW, default 4, operand width in bits.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 Port req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-007 Port req_a  input  NUM_REQ*DW  operand A, requester i at bits [i*DW +: DW].
REQ-008 Port req_b  input  NUM_REQ*DW  operand B, same packing as req_a.
REQ-009 Port rsp_valid  output  1  result valid.
REQ-010 Port rsp_ready  input  1  downstream accept.
REQ-011 Port rsp_sum  output  DW+1  unsigned sum A+B.
REQ-012 Port rsp_id  output  $clog2(NUM_REQ)  index of requester owning rsp_sum.

Function
REQ-013 FSM states IDLE, CALC, RESP; exactly one transaction in flight.
REQ-014 IDLE: req_ready SHALL be one-hot for the winning valid requester, zero if no req_valid; combinational from req_valid and rr pointer.
REQ-015 Arbitration round-robin: search starts at rr_ptr, wraps NUM_REQ-1 -> 0; on grant rr_ptr <= winner+1 (mod NUM_REQ).
REQ-016 Handshake req_valid[i] & req_ready[i] at edge E0: operands and id captured, IDLE -> CALC.
REQ-017 CALC: sub-module registers A+B at edge E1, CALC -> RESP unconditionally; req_ready all zero.
REQ-018 RESP: rsp_valid=1, rsp_sum/rsp_id stable until rsp_valid & rsp_ready edge, then RESP -> IDLE.
REQ-019 Latency: rsp_valid rises exactly 2 cycles after request handshake; max throughput one result per 3 cycles.
REQ-020 Sum width DW+1, never truncated (DW=4: 15+15 -> 30).
REQ-021 req_ready zero in CALC and RESP; requester withdrawing req_valid before handshake SHALL have no effect.
REQ-022 rsp_ready held low: remain in RESP indefinitely, no new grant.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, rr_ptr=0, rsp_valid=0, rsp_sum=0, rsp_id=0, req_ready=0.
REQ-024 Reset mid-transaction (CALC or RESP) SHALL discard it; no response issued after release.
REQ-025 First grant after reset SHALL favour requester 0 when multiple valid.

Configuration
REQ-026 Macro ADD_SCHED_STATS_EN defined: add output grant_cnt (NUM_REQ*8 bits), per-requester 8-bit counter incremented per request handshake, saturating at 255, reset to 0.
REQ-027 Macro undefined: grant_cnt port and counters absent; all other behaviour identical.

Structure
REQ-028 Shared package add_sched_pkg SHALL hold the FSM state enum (IDLE/CALC/RESP) and counter width constant STATS_W=8.
REQ-029 Sub-module add_unit SHALL implement the registered DW-bit adder (posedge clk, async active-low reset to 0, output DW+1 bits); add_sched instantiates exactly one.

Verification
REQ-030 Single requester: req 2 valid a=7 b=9 -> req_ready[2] same cycle, rsp_valid 2 cycles later, rsp_sum=16, rsp_id=2.
REQ-031 All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0, one response per 3 cycles.
REQ-032 Overflow width: a=15 b=15 -> rsp_sum=30 (5'b11110).
REQ-033 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_sum/rsp_id stable, req_ready=0 throughout; release -> IDLE next cycle.
REQ-034 Reset asserted in CALC -> outputs zero immediately; after release no rsp_valid until new handshake; next grant to lowest-index valid requester.
REQ-035 ADD_SCHED_STATS_EN: 300 grants to requester 1 -> grant_cnt[1]=255, others unchanged.
